// File: rtl/synth_voice_pkg.sv
// Shared types and default sizing for the polyphonic voice allocator.
package synth_voice_pkg;

    localparam int unsigned DEFAULT_NUM_VOICES = 4;
    localparam int unsigned DEFAULT_FREQ_BITS  = 12;
    localparam int unsigned DEFAULT_NOTE_BITS  = 7;
    localparam int unsigned DEFAULT_AGE_BITS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCAN   = 2'b01,
        ST_COMMIT = 2'b10
    } alloc_state_e;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b11
    } wave_sel_e;

endpackage

// File: rtl/voice_slot.sv
// Storage for one oscillator voice: pitch, waveform, note, gate and age.
module voice_slot #(
    parameter int unsigned FREQ_BITS = 12,
    parameter int unsigned NOTE_BITS = 7,
    parameter int unsigned AGE_BITS  = 4
) (
    input  logic                 main_clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 age_inc,
    input  logic                 gate_clr,
    input  logic [FREQ_BITS-1:0] ld_freq,
    input  logic [1:0]           ld_sel,
    input  logic [NOTE_BITS-1:0] ld_note,
    output logic [FREQ_BITS-1:0] freq,
    output logic [1:0]           sel,
    output logic [NOTE_BITS-1:0] note,
    output logic                 gate,
    output logic [AGE_BITS-1:0]  age
);

    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

    // A load restarts the voice; otherwise age saturates so the oldest stays distinguishable.
    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            freq <= '0;
            sel  <= '0;
            note <= '0;
            gate <= 1'b0;
            age  <= '0;
        end else if (load) begin
            freq <= ld_freq;
            sel  <= ld_sel;
            note <= ld_note;
            gate <= 1'b1;
            age  <= '0;
        end else begin
            if (age_inc && (age != AGE_MAX)) begin
                age <= age + AGE_BITS'(1);
            end
            if (gate_clr) begin
                gate <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Note-event voice allocator: scans voices one per cycle, then retriggers, fills or steals.
// voice_rst is active-high; downstream oscillator reset_n pins take it through an inverter.
module voice_allocator
    import synth_voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int unsigned FREQ_BITS  = DEFAULT_FREQ_BITS,
    parameter int unsigned NOTE_BITS  = DEFAULT_NOTE_BITS,
    parameter int unsigned AGE_BITS   = DEFAULT_AGE_BITS
) (
    input  logic                            main_clk,
    input  logic                            reset_n,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    input  logic [FREQ_BITS-1:0]            ev_freq,
    input  logic [1:0]                      ev_sel,
    output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
    output logic [NUM_VOICES*2-1:0]         voice_sel,
    output logic [NUM_VOICES-1:0]           voice_gate,
    output logic [NUM_VOICES-1:0]           voice_rst,
    output logic                            steal_pulse,
    output logic                            busy
);

    localparam int unsigned IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned LAST_IDX = NUM_VOICES - 1;

    alloc_state_e state;
    alloc_state_e state_nxt;
    logic         accept_c;
    logic         commit_c;

    logic                 cap_on;
    logic [NOTE_BITS-1:0] cap_note;
    logic [FREQ_BITS-1:0] cap_freq;
    logic [1:0]           cap_sel;

    logic [IDX_W-1:0]    scan_idx;
    logic                match_found;
    logic                free_found;
    logic [IDX_W-1:0]    match_idx;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    old_idx;
    logic [AGE_BITS-1:0] old_age;

    logic [NOTE_BITS-1:0]  slot_note [NUM_VOICES];
    logic [AGE_BITS-1:0]   slot_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] load_c;
    logic [NUM_VOICES-1:0] age_inc_c;
    logic [NUM_VOICES-1:0] gate_clr_c;
    logic [IDX_W-1:0]      tgt_idx_c;
    logic                  steal_c;

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ev_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            ev_ready <= (state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        commit_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev_valid && ev_ready) begin
                    accept_c  = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_idx == IDX_W'(LAST_IDX)) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit_c  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Event capture and candidate tracking; slot contents are stable throughout the scan.
    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_on      <= 1'b0;
            cap_note    <= '0;
            cap_freq    <= '0;
            cap_sel     <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (accept_c) begin
            cap_on      <= ev_on;
            cap_note    <= ev_note;
            cap_freq    <= ev_freq;
            cap_sel     <= ev_sel;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (state == ST_SCAN) begin
            scan_idx <= scan_idx + IDX_W'(1);
            if (!match_found && voice_gate[scan_idx] && (slot_note[scan_idx] == cap_note)) begin
                match_found <= 1'b1;
                match_idx   <= scan_idx;
            end
            if (!free_found && !voice_gate[scan_idx]) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (slot_age[scan_idx] > old_age) begin
                old_idx <= scan_idx;
                old_age <= slot_age[scan_idx];
            end
        end
    end

    always_comb begin
        tgt_idx_c  = match_found ? match_idx : (free_found ? free_idx : old_idx);
        steal_c    = cap_on && !match_found && !free_found;
        load_c     = '0;
        age_inc_c  = '0;
        gate_clr_c = '0;
        if (commit_c) begin
            if (cap_on) begin
                for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                    if (IDX_W'(i) == tgt_idx_c) begin
                        load_c[i] = 1'b1;
                    end else if (voice_gate[i]) begin
                        age_inc_c[i] = 1'b1;
                    end
                end
            end else if (match_found) begin
                gate_clr_c[match_idx] = 1'b1;
            end
        end
    end

    assign voice_rst   = load_c;
    assign steal_pulse = commit_c && steal_c;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot #(
            .FREQ_BITS (FREQ_BITS),
            .NOTE_BITS (NOTE_BITS),
            .AGE_BITS  (AGE_BITS)
        ) u_slot (
            .main_clk  (main_clk),
            .reset_n   (reset_n),
            .load      (load_c[g]),
            .age_inc   (age_inc_c[g]),
            .gate_clr  (gate_clr_c[g]),
            .ld_freq   (cap_freq),
            .ld_sel    (cap_sel),
            .ld_note   (cap_note),
            .freq      (voice_freq[g*FREQ_BITS +: FREQ_BITS]),
            .sel       (voice_sel[g*2 +: 2]),
            .note      (slot_note[g]),
            .gate      (voice_gate[g]),
            .age       (slot_age[g])
        );
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against a per-event behavioural voice model.
module tb_voice_allocator;

    localparam int unsigned NV = 4;
    localparam int unsigned FB = 12;
    localparam int unsigned NB = 7;
    localparam int unsigned AB = 4;
    localparam int unsigned AGE_SAT = (1 << AB) - 1;

    logic          main_clk = 1'b0;
    logic          reset_n  = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_on    = 1'b0;
    logic [NB-1:0] ev_note  = '0;
    logic [FB-1:0] ev_freq  = '0;
    logic [1:0]    ev_sel   = '0;
    logic [NV*FB-1:0] voice_freq;
    logic [NV*2-1:0]  voice_sel;
    logic [NV-1:0]    voice_gate;
    logic [NV-1:0]    voice_rst;
    logic             steal_pulse;
    logic             busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    // Behavioural model: one entry per voice
    logic          m_gate [NV];
    logic [FB-1:0] m_freq [NV];
    logic [1:0]    m_sel  [NV];
    logic [NB-1:0] m_note [NV];
    int unsigned   m_age  [NV];

    voice_allocator #(
        .NUM_VOICES (NV),
        .FREQ_BITS  (FB),
        .NOTE_BITS  (NB),
        .AGE_BITS   (AB)
    ) dut (
        .main_clk    (main_clk),
        .reset_n     (reset_n),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_note     (ev_note),
        .ev_freq     (ev_freq),
        .ev_sel      (ev_sel),
        .voice_freq  (voice_freq),
        .voice_sel   (voice_sel),
        .voice_gate  (voice_gate),
        .voice_rst   (voice_rst),
        .steal_pulse (steal_pulse),
        .busy        (busy)
    );

    always #5 main_clk = ~main_clk;
    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0;
            m_freq[i] = '0;
            m_sel[i]  = '0;
            m_note[i] = '0;
            m_age[i]  = 0;
        end
    endfunction

    // Match first, then free, then oldest (ties -> lowest index); returns expected pulses.
    function automatic void model_apply(input logic on, input logic [NB-1:0] note,
                                        input logic [FB-1:0] f, input logic [1:0] s,
                                        output logic [NV-1:0] rst, output logic steal);
        int m   = -1;
        int fr  = -1;
        int old = 0;
        int tgt;
        rst   = '0;
        steal = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (m < 0 && m_gate[i] && m_note[i] == note) m = i;
            if (fr < 0 && !m_gate[i]) fr = i;
            if (m_age[i] > m_age[old]) old = i;
        end
        if (on) begin
            tgt   = (m >= 0) ? m : ((fr >= 0) ? fr : old);
            steal = (m < 0) && (fr < 0);
            for (int i = 0; i < NV; i++) begin
                if (i != tgt && m_gate[i] && m_age[i] < AGE_SAT) m_age[i]++;
            end
            m_freq[tgt] = f;
            m_sel[tgt]  = s;
            m_note[tgt] = note;
            m_gate[tgt] = 1'b1;
            m_age[tgt]  = 0;
            rst[tgt]    = 1'b1;
        end else if (m >= 0) begin
            m_gate[m] = 1'b0;
        end
    endfunction

    function automatic void model_pack(output logic [NV*FB-1:0] f, output logic [NV*2-1:0] s,
                                       output logic [NV-1:0] g);
        for (int i = 0; i < NV; i++) begin
            f[i*FB +: FB] = m_freq[i];
            s[i*2 +: 2]   = m_sel[i];
            g[i]          = m_gate[i];
        end
    endfunction

    task automatic check_voices(input string tag);
        logic [NV*FB-1:0] ef;
        logic [NV*2-1:0]  es;
        logic [NV-1:0]    eg;
        model_pack(ef, es, eg);
        check_eq({tag, "_freq"}, 64'(voice_freq), 64'(ef));
        check_eq({tag, "_sel"},  64'(voice_sel),  64'(es));
        check_eq({tag, "_gate"}, 64'(voice_gate), 64'(eg));
    endtask

    task automatic do_reset();
        @(negedge main_clk);
        ev_valid = 1'b0;
        reset_n  = 1'b0;
        model_reset();
        @(negedge main_clk);
        reset_n = 1'b1;
        @(negedge main_clk);
    endtask

    // Offer one event, then check every cycle up to and including the first updated cycle.
    task automatic send_ev(input logic on, input int note, input logic [FB-1:0] f, input logic [1:0] s);
        logic [NV-1:0] exp_rst;
        logic          exp_steal;
        int unsigned   w = 0;
        @(negedge main_clk);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = NB'(note);
        ev_freq  = f;
        ev_sel   = s;
        while (!ev_ready && w < 20) begin
            @(negedge main_clk);
            w++;
        end
        if (!ev_ready) begin
            check_eq("ready_timeout", 64'(ev_ready), 64'(1));
            ev_valid = 1'b0;
            return;
        end
        @(posedge main_clk);
        #1;
        // Garbage while busy must be ignored.
        ev_valid = 1'($urandom_range(0, 1));
        ev_on    = 1'($urandom);
        ev_note  = NB'($urandom);
        ev_freq  = FB'($urandom);
        ev_sel   = 2'($urandom);
        for (int k = 1; k <= 6; k++) begin
            @(negedge main_clk);
            if (k <= 5) begin
                check_eq("ready_low", 64'(ev_ready), 64'(0));
                check_eq("busy_high", 64'(busy), 64'(1));
                check_voices("hold");
                if (k == 5) begin
                    model_apply(on, NB'(note), f, s, exp_rst, exp_steal);
                    check_eq("commit_rst",   64'(voice_rst),   64'(exp_rst));
                    check_eq("commit_steal", 64'(steal_pulse), 64'(exp_steal));
                    ev_valid = 1'b0;
                end else begin
                    check_eq("scan_rst",   64'(voice_rst),   64'(0));
                    check_eq("scan_steal", 64'(steal_pulse), 64'(0));
                end
            end else begin
                check_eq("ready_back", 64'(ev_ready), 64'(1));
                check_eq("busy_low",   64'(busy),     64'(0));
                check_eq("post_rst",   64'(voice_rst), 64'(0));
                check_voices("update");
            end
        end
    endtask

    // ev_valid held high: one acceptance every 6 cycles, ready low for 5 in between.
    task automatic hold_valid_burst(input int n);
        logic [NV-1:0] r;
        logic          st;
        int unsigned   last = 0;
        int unsigned   lowc;
        @(negedge main_clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = NB'(50);
        ev_freq  = FB'(12'h0AB);
        ev_sel   = 2'b11;
        for (int e = 0; e < n; e++) begin
            lowc = 0;
            while (!ev_ready && lowc < 20) begin
                lowc++;
                @(negedge main_clk);
            end
            if (e > 0) begin
                check_eq("burst_ready_low", 64'(lowc), 64'(5));
                check_eq("burst_interval",  64'(cyc - last), 64'(6));
            end
            last = cyc;
            model_apply(1'b1, NB'(50), FB'(12'h0AB), 2'b11, r, st);
            @(posedge main_clk);
            #1;
            if (e == n - 1) ev_valid = 1'b0;
            @(negedge main_clk);
        end
        repeat (5) @(negedge main_clk);
        check_voices("burst_end");
    endtask

    task automatic reset_mid_scan();
        @(negedge main_clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = NB'(72);
        ev_freq  = FB'(12'h3C3);
        ev_sel   = 2'b01;
        @(posedge main_clk);
        #1 ev_valid = 1'b0;
        @(posedge main_clk);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("abort_gate",  64'(voice_gate),  64'(0));
        check_eq("abort_freq",  64'(voice_freq),  64'(0));
        check_eq("abort_rst",   64'(voice_rst),   64'(0));
        check_eq("abort_steal", 64'(steal_pulse), 64'(0));
        check_eq("abort_ready", 64'(ev_ready),    64'(0));
        check_eq("abort_busy",  64'(busy),        64'(0));
        @(negedge main_clk);
        reset_n = 1'b1;
        @(negedge main_clk);
        check_eq("abort_ready_rise", 64'(ev_ready),  64'(1));
        check_eq("abort_no_rst",     64'(voice_rst), 64'(0));
        check_voices("abort_after");
    endtask

    initial begin
        logic [1:0] sel_tab [3];
        sel_tab[0] = 2'b00;
        sel_tab[1] = 2'b01;
        sel_tab[2] = 2'b11;
        model_reset();

        repeat (2) @(negedge main_clk);
        check_eq("rst_ready", 64'(ev_ready),    64'(0));
        check_eq("rst_busy",  64'(busy),        64'(0));
        check_eq("rst_rst",   64'(voice_rst),   64'(0));
        check_eq("rst_steal", 64'(steal_pulse), 64'(0));
        check_voices("rst");
        reset_n = 1'b1;
        @(negedge main_clk);
        check_eq("ready_after_rst", 64'(ev_ready), 64'(1));

        // First note lands on voice 0
        send_ev(1'b1, 60, FB'(12'h100), 2'b01);
        check_eq("first_v0_freq", 64'(voice_freq[FB-1:0]), 64'(12'h100));
        check_eq("first_v0_gate", 64'(voice_gate),         64'(4'b0001));

        // Fill, then steal the oldest
        send_ev(1'b1, 62, FB'(12'h111), 2'b00);
        send_ev(1'b1, 64, FB'(12'h122), 2'b11);
        send_ev(1'b1, 67, FB'(12'h133), 2'b01);
        check_eq("full_gate", 64'(voice_gate), 64'(4'hF));
        send_ev(1'b1, 69, FB'(12'h144), 2'b00);
        check_eq("stolen_v0_freq", 64'(voice_freq[FB-1:0]), 64'(12'h144));

        // Retrigger of a held note
        do_reset();
        send_ev(1'b1, 60, FB'(12'h100), 2'b01);
        send_ev(1'b1, 60, FB'(12'h200), 2'b01);
        check_eq("retrig_gate", 64'(voice_gate),         64'(4'b0001));
        check_eq("retrig_freq", 64'(voice_freq[FB-1:0]), 64'(12'h200));

        // Note-off with and without a match
        send_ev(1'b1, 62, FB'(12'h0F0), 2'b11);
        send_ev(1'b0, 62, FB'(12'h000), 2'b00);
        check_eq("off_gate",  64'(voice_gate),            64'(4'b0001));
        check_eq("off_freq1", 64'(voice_freq[2*FB-1:FB]), 64'(12'h0F0));
        send_ev(1'b0, 70, FB'(12'h000), 2'b00);

        hold_valid_burst(4);

        send_ev(1'b1, 30, FB'(12'h011), 2'b01);
        reset_mid_scan();

        // Age saturation: keep retriggering one voice while the others age
        for (int i = 0; i < 4; i++) send_ev(1'b1, 40 + i, FB'(12'h400 + i), 2'b00);
        for (int i = 0; i < 20; i++) send_ev(1'b1, 43, FB'($urandom), 2'b01);
        send_ev(1'b1, 44, FB'(12'h7AA), 2'b11);
        send_ev(1'b1, 45, FB'(12'h7BB), 2'b11);

        // Randomized traffic over a small note pool to force matches and steals
        for (int i = 0; i < 80; i++) begin
            send_ev(1'($urandom_range(0, 3) != 0), 48 + int'($urandom_range(0, 7)),
                    FB'($urandom), sel_tab[$urandom_range(0, 2)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of oscillator voices managed (2..8).
REQ-002 Parameter FREQ_BITS, default 12: width of the oscillator phase increment.
REQ-003 Parameter NOTE_BITS, default 7: width of the note number.
REQ-004 Parameter AGE_BITS, default 4: width of the per-voice age counter.
REQ-005 main_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 ev_valid  in  1  note event offered.
REQ-008 ev_ready  out  1  allocator can accept an event.
REQ-009 ev_on  in  1  1 = note-on, 0 = note-off.
REQ-010 ev_note  in  NOTE_BITS  note number.
REQ-011 ev_freq  in  FREQ_BITS  phase increment for a note-on.
REQ-012 ev_sel  in  2  waveform select for a note-on (00 square, 01 saw, 11 triangle).
REQ-013 voice_freq  out  NUM_VOICES*FREQ_BITS  per-voice increment; voice i occupies bits [i*FREQ_BITS +: FREQ_BITS].
REQ-014 voice_sel  out  NUM_VOICES*2  per-voice waveform select; voice i occupies bits [i*2 +: 2].
REQ-015 voice_gate  out  NUM_VOICES  1 = voice sounding.
REQ-016 voice_rst  out  NUM_VOICES  one-cycle pulse that clears the oscillator phase of a voice.
REQ-017 steal_pulse  out  1  one-cycle pulse when a sounding voice is taken over.
REQ-018 busy  out  1  1 whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, SCAN and COMMIT.
REQ-020 IDLE: ev_ready = 1; on ev_valid && ev_ready, capture ev_on, ev_note, ev_freq and ev_sel, clear the scan index, and go to SCAN.
REQ-021 ev_ready SHALL be 0 in SCAN and COMMIT; events are not queued.
REQ-022 SCAN SHALL examine one voice per cycle, index 0 upward, and go to COMMIT after voice NUM_VOICES-1.
REQ-023 During SCAN the FSM SHALL record three candidates:
- match: lowest-index voice with gate = 1 and a stored note equal to the captured note;
- free: lowest-index voice with gate = 0;
- oldest: voice with the largest age; ties go to the lowest index.
REQ-024 COMMIT lasts one cycle, applies the update, then returns to IDLE; an event accepted in cycle T updates the outputs in cycle T+NUM_VOICES+2.
REQ-025 Note-on target priority SHALL be match, then free, then oldest. steal_pulse is asserted only when the target is oldest.
REQ-026 Note-on commit on the target voice:
- freq and sel loaded from the captured event;
- note stored, gate set to 1;
- voice_rst pulsed for exactly the COMMIT cycle;
- age cleared to 0.
REQ-027 Note-on commit on every other gated voice: age incremented, saturating at 2^AGE_BITS-1.
REQ-028 Note-off with a match SHALL clear that voice's gate; its freq, sel, note and age are kept.
REQ-029 Note-off with no match SHALL change no voice state and return to IDLE.
REQ-030 voice_freq, voice_sel and voice_gate SHALL be registered and change only in COMMIT or on reset.
REQ-031 Changing ev_* while ev_ready = 0 SHALL have no effect.

Reset
REQ-032 While reset_n = 0:
- state = IDLE, ev_ready = 0, busy = 0;
- all voice_gate, voice_freq, voice_sel, voice_rst, ages and stored notes = 0;
- steal_pulse = 0.
REQ-033 ev_ready SHALL rise on the first main_clk edge after reset_n deasserts.
REQ-034 Reset asserted during SCAN or COMMIT SHALL abort the event with no partial voice update.

Structure
REQ-035 Package synth_voice_pkg SHALL hold:
- the FSM state enum;
- the waveform-select encodings;
- the default widths (NUM_VOICES, FREQ_BITS, NOTE_BITS, AGE_BITS).
REQ-036 Per-voice storage (freq, sel, note, gate, age) and its update logic SHALL be the sub-module voice_slot, instantiated NUM_VOICES times.
REQ-037 The voice_rst outputs SHALL connect to the reset input of each downstream oscillator through an inverter, since voice_rst is active-high and reset_n is active-low.

Verification
REQ-038 Reset, then note-on note=60 freq=0x100 sel=01 → voice 0: gate=1, freq=0x100, sel=01, voice_rst[0] pulse, output update 6 cycles after acceptance (NUM_VOICES=4).
REQ-039 Note-on notes 60,62,64,67 → voices 0..3 gated; a fifth note-on note=69 → voice 0 stolen (age 3), steal_pulse=1, freq updated.
REQ-040 Note-on 60 then note-on 60 again with freq=0x200 → voice 0 retriggered, voice 1 stays gate=0, steal_pulse=0.
REQ-041 Note-off 62 when voice 1 holds 62 → voice_gate[1]=0 with freq unchanged; note-off 70 with no match → all voice outputs unchanged.
REQ-042 Hold ev_valid=1 continuously → ev_ready low for 5 cycles per event, one event accepted per 6 cycles; age saturates at 15 after 20 further note-ons.
REQ-043 Assert reset_n=0 in the second SCAN cycle → all gates 0 and no voice_rst pulse; ev_ready=1 one cycle after release.
